cg_rate_scheduler: RTL
======================

# cg_rate_scheduler

Sequences the shared `context_bit_lookup` datapath across one 4x4 coefficient group (CG) in the CABAC rate estimator. The block accepts quantised levels in reverse scan order, classifies each one into a level case, and tracks the per-CG `c1Idx`/`c2Idx` context counters. For each nonzero coefficient it issues one lookup request and accumulates the returned context bits into a per-CG rate, which the RDOQ cost stage consumes.

## Interface
Parameters:
- `CG_SIZE`, 16: maximum number of coefficients per group.
- `ACC_W`, 32: width of the accumulator and `cg_bits`.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `coef_valid` in 1: coefficient beat valid.
- `coef_ready` out 1: block can accept a beat.
- `coef_level` in 16: absolute quantised level.
- `coef_gt1_cost` in 16: greater-one cost for this coefficient.
- `coef_abs_cost` in 16: level-abs cost for this coefficient.
- `coef_last` in 1: final coefficient of the CG.
- `lk_start` out 1: lookup request pulse.
- `lk_level_case` out 2: 0 = ZERO, 1 = ONE, 2 = TWO, 3 = BASEPLUS.
- `lk_c1Idx` out 8: c1Idx presented to the lookup.
- `lk_c2Idx` out 8: c2Idx presented to the lookup.
- `lk_greater_one_cost` out 16: greater-one cost presented to the lookup.
- `lk_level_abs_cost` out 16: level-abs cost presented to the lookup.
- `lk_context_bits` in 32: lookup result.
- `lk_done` in 1: lookup result valid.
- `cg_bits` out ACC_W: CG rate total, valid with `cg_valid`.
- `cg_valid` out 1: one-cycle pulse per CG.
- `busy` out 1: block is not in IDLE.

## Operation
- **FSM states:** IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - `coef_ready` = 1.
  - A beat is accepted when `coef_valid && coef_ready`.
  - On acceptance, compute `level_case`: 0 if level = 0; 1 if level = 1; 2 if level = 2; 3 if level ≥ 3.
- **Zero coefficient:** no lookup; adds 0; counters unchanged.
  - If the beat is last, or it is the `CG_SIZE`-th beat, go to DONE.
  - Otherwise stay in IDLE.
- **Nonzero coefficient:** register case, costs and the *current* `c1Idx`/`c2Idx` into the `lk_*` outputs, then go to ISSUE.
- **ISSUE:** `lk_start` = 1 for exactly one cycle; go to WAIT.
- **WAIT**
  - Hold all `lk_*` data outputs stable and keep `lk_start` = 0.
  - Lookup latency is arbitrary (≥ 1 cycle).
  - On `lk_done`:
    - `acc += lk_context_bits`.
    - `c1Idx` increments, saturating at 8.
    - If case ≥ 2 and pre-update `c1Idx` < 8, `c2Idx` increments, saturating at 2.
    - If the beat was last or the count reached `CG_SIZE`, go to DONE; otherwise go to IDLE.
- **DONE**
  - `cg_valid` = 1 and `cg_bits` = acc for one cycle.
  - Clear acc, `c1Idx`, `c2Idx` and the beat count; go to IDLE.
- **Accumulator width:** max 16 × 0x1FFFF < 2^21, so there is no overflow in ACC_W = 32; the add is plain unsigned.
- **Group termination:** a CG ends at whichever comes first, `coef_last` or `CG_SIZE` beats. A 17th beat is never merged into the same group.
- **Stray `lk_done`:** ignored outside WAIT.

## Timing
- **Reset values:** all outputs 0; state IDLE; acc, counters and beat count 0.
- **Asynchronous reset mid-operation:** aborts the CG immediately with no `cg_valid`; the next beat starts a fresh CG.
- **Nonzero coefficient:** accept edge → ISSUE (`lk_start` high) on the next cycle. With lookup latency L cycles from the `lk_start` cycle to `lk_done`, `coef_ready` returns on the cycle after `lk_done`, for a throughput of L + 2 cycles per coefficient.
- **Zero coefficient:** 1 cycle per coefficient (`coef_ready` stays high).
- **`cg_valid`:** asserted the cycle after the last acceptance (zero coefficient) or the cycle after the final `lk_done`. `coef_ready` = 0 during DONE.
- **Back-to-back CGs:** the first beat of the next CG is accepted the cycle after DONE.

## Test plan
1. Levels 1, 2, 0, 3 (last).
   - gt1/abs costs: (100, –), (120, 80), (–, –), (50, 30); real lookup.
   - Required: lookup bits 100, 200, skip, 50 (c2Idx = 1 gates abs); `cg_bits` = 350; exactly 3 `lk_start` pulses.
2. Eight level-1 beats (gt1 = 10), then a level-3 beat (gt1 = 60, abs = 40, last).
   - Required: ninth lookup presents `c1Idx` = 8 and returns 0; `cg_bits` = 80.
3. 16 level-1 beats (gt1 = 5), `coef_last` never asserted.
   - Required: `cg_valid` after the 16th beat with `cg_bits` = 40 (8 × 5, then c1Idx saturated); the 17th beat starts a new CG.
4. Stub lookup with `lk_done` 3 cycles after `lk_start`.
   - Required: `lk_start` high 1 cycle only; `lk_*` data stable until `lk_done`; `coef_ready` low in between.
5. Assert `rst_n` = 0 during WAIT of the second coefficient.
   - Required: all outputs 0 immediately; no `cg_valid`.
   - Next CG: single level-1 beat (gt1 = 77, last) yields `cg_bits` = 77.
6. Two consecutive CGs: [2 (120/80, last)], then [1 (25, last)].
   - Required: `cg_bits` 200 then 25, each with a single-cycle `cg_valid`.

Source files
------------

// File: rtl/cg_rate_scheduler.sv
// Per-CG scheduler for the CABAC rate estimator: classifies levels, tracks c1Idx/c2Idx,
// issues one context_bit_lookup per nonzero coefficient and accumulates the returned bits.
module cg_rate_scheduler #(
    parameter int unsigned CG_SIZE = 16,
    parameter int unsigned ACC_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             coef_valid,
    output logic             coef_ready,
    input  logic [15:0]      coef_level,
    input  logic [15:0]      coef_gt1_cost,
    input  logic [15:0]      coef_abs_cost,
    input  logic             coef_last,
    output logic             lk_start,
    output logic [1:0]       lk_level_case,
    output logic [7:0]       lk_c1Idx,
    output logic [7:0]       lk_c2Idx,
    output logic [15:0]      lk_greater_one_cost,
    output logic [15:0]      lk_level_abs_cost,
    input  logic [31:0]      lk_context_bits,
    input  logic             lk_done,
    output logic [ACC_W-1:0] cg_bits,
    output logic             cg_valid,
    output logic             busy
);

    localparam int unsigned CNT_W  = $clog2(CG_SIZE + 1);
    localparam int unsigned IDX_W  = 8;
    localparam int unsigned COST_W = 16;
    localparam int unsigned C1_MAX = 8;
    localparam int unsigned C2_MAX = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [IDX_W-1:0]   c1_q, c1_d, c2_q, c2_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_q, last_d;
    logic [1:0]         lvl_case;

    logic               ready_d, start_d, valid_d, busy_d;
    logic [1:0]         case_d;
    logic [IDX_W-1:0]   c1_out_d, c2_out_d;
    logic [COST_W-1:0]  gt1_d, abs_d;
    logic [ACC_W-1:0]   cg_bits_d;

    // Level classification: ZERO / ONE / TWO / BASEPLUS
    assign lvl_case = (coef_level >= 16'd3) ? 2'd3 : coef_level[1:0];

    // State, context counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q             <= IDLE;
            acc_q               <= '0;
            c1_q                <= '0;
            c2_q                <= '0;
            cnt_q               <= '0;
            last_q              <= 1'b0;
            coef_ready          <= 1'b0;
            lk_start            <= 1'b0;
            lk_level_case       <= '0;
            lk_c1Idx            <= '0;
            lk_c2Idx            <= '0;
            lk_greater_one_cost <= '0;
            lk_level_abs_cost   <= '0;
            cg_bits             <= '0;
            cg_valid            <= 1'b0;
            busy                <= 1'b0;
        end else begin
            state_q             <= state_d;
            acc_q               <= acc_d;
            c1_q                <= c1_d;
            c2_q                <= c2_d;
            cnt_q               <= cnt_d;
            last_q              <= last_d;
            coef_ready          <= ready_d;
            lk_start            <= start_d;
            lk_level_case       <= case_d;
            lk_c1Idx            <= c1_out_d;
            lk_c2Idx            <= c2_out_d;
            lk_greater_one_cost <= gt1_d;
            lk_level_abs_cost   <= abs_d;
            cg_bits             <= cg_bits_d;
            cg_valid            <= valid_d;
            busy                <= busy_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        c1_d      = c1_q;
        c2_d      = c2_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        case_d    = lk_level_case;
        c1_out_d  = lk_c1Idx;
        c2_out_d  = lk_c2Idx;
        gt1_d     = lk_greater_one_cost;
        abs_d     = lk_level_abs_cost;

        unique case (state_q)
            IDLE: begin
                if (coef_valid && coef_ready) begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    last_d = coef_last || (cnt_d == CNT_W'(CG_SIZE));
                    if (lvl_case == 2'd0) begin
                        if (last_d) state_d = DONE;
                    end else begin
                        case_d   = lvl_case;
                        c1_out_d = c1_q;
                        c2_out_d = c2_q;
                        gt1_d    = coef_gt1_cost;
                        abs_d    = coef_abs_cost;
                        state_d  = ISSUE;
                    end
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (lk_done) begin
                    acc_d = acc_q + ACC_W'(lk_context_bits);
                    if (c1_q < IDX_W'(C1_MAX)) c1_d = c1_q + IDX_W'(1);
                    // c2Idx only advances while c1Idx has not yet saturated
                    if ((lk_level_case >= 2'd2) && (c1_q < IDX_W'(C1_MAX)) && (c2_q < IDX_W'(C2_MAX)))
                        c2_d = c2_q + IDX_W'(1);
                    state_d = last_q ? DONE : IDLE;
                end
            end
            DONE: begin
                acc_d   = '0;
                c1_d    = '0;
                c2_d    = '0;
                cnt_d   = '0;
                last_d  = 1'b0;
                state_d = IDLE;
            end
        endcase

        ready_d   = (state_d == IDLE);
        start_d   = (state_d == ISSUE);
        valid_d   = (state_d == DONE);
        busy_d    = (state_d != IDLE);
        cg_bits_d = (state_d == DONE) ? acc_d : '0;
    end

endmodule
